// File: rtl/ysyx_24110015_axi_lite_master_if.sv
// -----------------------------------------------------------------------------
// axi_lite_if
// Purpose : AXI-lite channel bundle shared by the core-side master bridge and
//           the memory/UART slaves behind the crossbar.
// Params  : ADDR_W - address width, DATA_W - data width (strobe = DATA_W/8)
// Signals : AR/R read channels, AW/W/B write channels (no prot, no burst).
// Modports: master - drives ar*/aw*/w*/rready/bready, samples the rest
//           slave  - the mirror image
// -----------------------------------------------------------------------------
interface axi_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready,
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready
   );

   modport slave (
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready,
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready
   );
endinterface

// File: rtl/ysyx_24110015_axi_lite_master.sv
// -----------------------------------------------------------------------------
// ysyx_24110015_axi_lite_master
// Purpose : single-outstanding AXI-lite initiator between the CPU memory port
//           (IFU/LSU) and the crossbar. One read or write request is accepted
//           in IDLE, the AR/R or AW/W/B handshakes are run, and a one-cycle
//           response pulse is returned.
// Ports   : clk, rst (synchronous, active-high)
//           req_valid/req_ready/req_wen/req_addr/req_wdata/req_wstrb - request
//           rsp_valid/rsp_rdata/rsp_err                            - response
//           axi (axi_lite_if.master)                               - bus side
// Config  : define YSYX_AXIM_TIMEOUT_EN to abort any wait state that lasts
//           TIMEOUT_CYCLES cycles with an error response. Without it the
//           bridge waits indefinitely.
// -----------------------------------------------------------------------------
module ysyx_24110015_axi_lite_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   axi_lite_if.master          axi
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AW_W = 3'd3,
      S_B    = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                aw_fin_s;
   logic                w_fin_s;

`ifdef YSYX_AXIM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
`endif

   // Next-state, request latch and response computation.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      // A channel counts as finished if it completed earlier or completes now.
      aw_fin_s    = aw_done_q | axi.awready;
      w_fin_s     = w_done_q | axi.wready;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               wstrb_d   = req_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_wen ? S_AW_W : S_AR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_AR: begin
            if (axi.arready) begin
               state_d = S_R;
            end else begin
               state_d = S_AR;
            end
         end
         S_R: begin
            if (axi.rvalid) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = axi.rdata;
               rsp_err_d   = (axi.rresp != 2'b00);
            end else begin
               state_d = S_R;
            end
         end
         S_AW_W: begin
            aw_done_d = aw_fin_s;
            w_done_d  = w_fin_s;
            if (aw_fin_s && w_fin_s) begin
               state_d = S_B;
            end else begin
               state_d = S_AW_W;
            end
         end
         S_B: begin
            if (axi.bvalid) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = (axi.bresp != 2'b00);
            end else begin
               state_d = S_B;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef YSYX_AXIM_TIMEOUT_EN
      // Counter restarts on any state change; expiry abandons the bus transfer.
      tmo_cnt_d = '0;
      if (state_q == S_IDLE) begin
         tmo_cnt_d = '0;
      end else if (state_d != state_q) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
         state_d     = S_IDLE;
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
         rsp_rdata_d = '0;
         tmo_cnt_d   = '0;
      end else begin
         tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
`endif
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef YSYX_AXIM_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef YSYX_AXIM_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   // Every output is a pure decode of registered state, never of bus inputs.
   assign req_ready   = (state_q == S_IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign axi.arvalid = (state_q == S_AR);
   assign axi.araddr  = addr_q;
   assign axi.rready  = (state_q == S_R);
   assign axi.awvalid = (state_q == S_AW_W) && !aw_done_q;
   assign axi.awaddr  = addr_q;
   assign axi.wvalid  = (state_q == S_AW_W) && !w_done_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.bready  = (state_q == S_B);

endmodule

// File: tb/tb_ysyx_24110015_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_ysyx_24110015_axi_lite_master
// Self-checking bench: a delay-configurable AXI-lite slave drives the bus,
// and each scenario task compares responses against values derived from the
// request, the slave configuration and the handshake latency formulas.
// -----------------------------------------------------------------------------
module tb_ysyx_24110015_axi_lite_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   axi_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   ysyx_24110015_axi_lite_master #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
   ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .axi(axi.master)
   );

   always #5 clk = ~clk;

   // ---------------- slave configuration and observations -------------------
   int          cfg_ar, cfg_r, cfg_aw, cfg_w, cfg_b;
   logic [31:0] cfg_rdata;
   logic [1:0]  cfg_rresp, cfg_bresp;
   int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   bit          pend_r, pend_b, aw_seen, w_seen;
   bit          ar_act, aw_act, w_act, proto_err;
   logic [31:0] ar_first, rec_araddr, rec_awaddr, rec_wdata;
   logic [3:0]  rec_wstrb;
   int          aw_hs, w_hs, b_hs;
   logic [31:0] last_rdata;   // reference: rsp_rdata holds last read value

   // Slave: decides each ready/valid at the negedge, so every handshake it
   // grants is known before the posedge that completes it.
   initial begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      pend_r = 0; pend_b = 0; aw_seen = 0; w_seen = 0;
      ar_act = 0; aw_act = 0; w_act = 0; proto_err = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            axi.arready = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0;
            axi.wready = 1'b0; axi.bvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            pend_r = 0; pend_b = 0; aw_seen = 0; w_seen = 0;
            ar_act = 0; aw_act = 0; w_act = 0;
         end else begin
            if (pend_r) begin
               if (r_cnt >= cfg_r) begin
                  axi.rvalid = 1'b1; axi.rdata = cfg_rdata; axi.rresp = cfg_rresp;
                  if (axi.rready) pend_r = 0;
               end else begin
                  axi.rvalid = 1'b0; r_cnt++;
               end
            end else begin
               axi.rvalid = 1'b0;
            end
            if (axi.arvalid) begin
               if (!ar_act) begin ar_act = 1; ar_first = axi.araddr; end
               else if (axi.araddr !== ar_first) proto_err = 1;
               if (ar_cnt >= cfg_ar) begin
                  axi.arready = 1'b1; rec_araddr = axi.araddr;
                  ar_cnt = 0; ar_act = 0; pend_r = 1; r_cnt = 0;
               end else begin
                  axi.arready = 1'b0; ar_cnt++;
               end
            end else begin
               axi.arready = 1'b0;
               if (ar_act) proto_err = 1;
            end
            if (pend_b) begin
               if (b_cnt >= cfg_b) begin
                  axi.bvalid = 1'b1; axi.bresp = cfg_bresp;
                  if (axi.bready) begin pend_b = 0; b_hs++; end
               end else begin
                  axi.bvalid = 1'b0; b_cnt++;
               end
            end else begin
               axi.bvalid = 1'b0;
            end
            if (axi.awvalid) begin
               if (aw_seen) proto_err = 1;
               if (aw_cnt >= cfg_aw) begin
                  axi.awready = 1'b1; rec_awaddr = axi.awaddr;
                  aw_hs++; aw_cnt = 0; aw_seen = 1; aw_act = 0;
               end else begin
                  axi.awready = 1'b0; aw_cnt++; aw_act = 1;
               end
            end else begin
               axi.awready = 1'b0;
               if (aw_act) proto_err = 1;
            end
            if (axi.wvalid) begin
               if (w_seen) proto_err = 1;
               if (w_cnt >= cfg_w) begin
                  axi.wready = 1'b1; rec_wdata = axi.wdata; rec_wstrb = axi.wstrb;
                  w_hs++; w_cnt = 0; w_seen = 1; w_act = 0;
               end else begin
                  axi.wready = 1'b0; w_cnt++; w_act = 1;
               end
            end else begin
               axi.wready = 1'b0;
               if (w_act) proto_err = 1;
            end
            if (aw_seen && w_seen) begin
               aw_seen = 0; w_seen = 0; pend_b = 1; b_cnt = 0;
            end
         end
      end
   end

   // ---------------- reference model helpers ---------------------------------
   function automatic int exp_lat(input bit wen);
      int m;
      m = (cfg_aw > cfg_w) ? cfg_aw : cfg_w;
      return wen ? (3 + m + cfg_b) : (3 + cfg_ar + cfg_r);
   endfunction

   task automatic set_cfg(input int ar, r, aw, w, b);
      cfg_ar = ar; cfg_r = r; cfg_aw = aw; cfg_w = w; cfg_b = b;
   endtask

   // Issues one request and waits (bounded) for its response pulse.
   task automatic run_txn(input bit wen, input logic [31:0] addr, wdata,
                          input logic [3:0] strb, output int lat,
                          output logic [31:0] rd, output logic er, output bit got);
      int waitc;
      @(negedge clk);
      req_valid = 1'b1; req_wen = wen; req_addr = addr;
      req_wdata = wdata; req_wstrb = strb;
      waitc = 0;
      while (!req_ready && waitc < 50) begin @(negedge clk); waitc++; end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; got = 0; rd = 32'h0; er = 1'b0;
      while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
      if (rsp_valid) begin
         got = 1; rd = rsp_rdata; er = rsp_err;
         @(negedge clk);
         n_tests++;
         if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rsp_pulse: rsp_valid=%b, expected 0 one cycle later", rsp_valid);
         end
      end
   endtask

   // Checks one completed transaction against the reference expectations.
   task automatic check_txn(input string nm, input bit got, input int lat, input int elat,
                            input logic [31:0] rd, input logic [31:0] erd,
                            input logic er, input logic eer);
      n_tests++;
      if (!got) begin
         n_fail++; $display("FAIL %s_timeout: no rsp_valid within bound", nm);
      end else begin
         if (lat != elat) begin
            n_fail++; $display("FAIL %s_latency: got %0d, expected %0d", nm, lat, elat);
         end
         n_tests++;
         if (rd !== erd) begin
            n_fail++; $display("FAIL %s_rdata: got %h, expected %h", nm, rd, erd);
         end
         n_tests++;
         if (er !== eer) begin
            n_fail++; $display("FAIL %s_err: got %b, expected %b", nm, er, eer);
         end
      end
   endtask

   // ---------------- scenarios -----------------------------------------------
   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({req_ready, rsp_valid, rsp_err, axi.arvalid, axi.awvalid, axi.wvalid,
           axi.rready, axi.bready} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, expected 10000000",
                  {req_ready, rsp_valid, rsp_err, axi.arvalid, axi.awvalid,
                   axi.wvalid, axi.rready, axi.bready});
      end
      n_tests++;
      if ({rsp_rdata, axi.araddr, axi.awaddr, axi.wdata, axi.wstrb} !== 132'h0) begin
         n_fail++; $display("FAIL reset_data: data outputs not zero (rdata=%h araddr=%h)",
                            rsp_rdata, axi.araddr);
      end
      rst = 1'b0;
      last_rdata = 32'h0;
   endtask

   task automatic test_read_basic();
      int lat; logic [31:0] rd; logic er; bit got;
      set_cfg(0, 0, 0, 0, 0); cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
      run_txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, lat, rd, er, got);
      check_txn("read_basic", got, lat, 3, rd, 32'hDEAD_BEEF, er, 1'b0);
      last_rdata = 32'hDEAD_BEEF;
      n_tests++;
      if (rec_araddr !== 32'h8000_0000) begin
         n_fail++; $display("FAIL read_basic_araddr: got %h, expected 80000000", rec_araddr);
      end
   endtask

   task automatic test_write_split();
      int lat, b0, aw0; logic [31:0] rd; logic er; bit got;
      set_cfg(0, 0, 0, 2, 0); cfg_bresp = 2'b00;
      b0 = b_hs; aw0 = aw_hs;
      run_txn(1'b1, 32'hA000_03F8, 32'h41, 4'h1, lat, rd, er, got);
      check_txn("write_split", got, lat, exp_lat(1'b1), rd, last_rdata, er, 1'b0);
      n_tests++;
      if ({rec_awaddr, rec_wdata, rec_wstrb} !== {32'hA000_03F8, 32'h41, 4'h1}) begin
         n_fail++; $display("FAIL write_split_bus: got %h/%h/%h, expected a00003f8/00000041/1",
                            rec_awaddr, rec_wdata, rec_wstrb);
      end
      n_tests++;
      if ((b_hs - b0) != 1 || (aw_hs - aw0) != 1 || proto_err) begin
         n_fail++; $display("FAIL write_split_proto: b=%0d aw=%0d proto_err=%0d, expected 1 1 0",
                            b_hs - b0, aw_hs - aw0, proto_err);
      end
   endtask

   task automatic test_read_delayed_err();
      int lat; logic [31:0] rd; logic er; bit got;
      set_cfg(5, 3, 0, 0, 0); cfg_rdata = $urandom; cfg_rresp = 2'b10;
      run_txn(1'b0, 32'h1234_5678, 32'h0, 4'h0, lat, rd, er, got);
      check_txn("read_delayed", got, lat, 11, rd, cfg_rdata, er, 1'b1);
      last_rdata = cfg_rdata;
      n_tests++;
      if (proto_err || rec_araddr !== 32'h1234_5678) begin
         n_fail++; $display("FAIL read_delayed_araddr: proto_err=%0d araddr=%h, expected 0/12345678",
                            proto_err, rec_araddr);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] exp_rd;
      set_cfg(0, 0, 0, 0, 0); cfg_bresp = 2'b00; cfg_rresp = 2'b00;
      exp_rd = $urandom; cfg_rdata = exp_rd;
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0000_1000;
      req_wdata = 32'hCAFE_0001; req_wstrb = 4'hF;
      @(negedge clk);
      req_wen = 1'b0; req_addr = 32'h0000_2000; lat = 1;
      while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
      n_tests++;
      if (!rsp_valid || lat != 3 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_write: rsp=%b lat=%0d err=%b req_ready=%b, expected 1 3 0 1",
                            rsp_valid, lat, rsp_err, req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0; lat = 1;
      while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
      n_tests++;
      if (!rsp_valid || lat != 3 || rsp_rdata !== exp_rd || rec_araddr !== 32'h0000_2000) begin
         n_fail++; $display("FAIL b2b_read: rsp=%b lat=%0d rdata=%h araddr=%h, expected 1 3 %h 00002000",
                            rsp_valid, lat, rsp_rdata, rec_araddr, exp_rd);
      end
      last_rdata = exp_rd;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int seen; int lat; logic [31:0] rd; logic er; bit got;
      set_cfg(0, 0, 10, 10, 0);
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h5555_0000;
      req_wdata = 32'h1; req_wstrb = 4'h3;
      @(negedge clk);
      req_valid = 1'b0;
      n_tests++;
      if ({axi.awvalid, axi.wvalid} !== 2'b11) begin
         n_fail++; $display("FAIL rst_mid_pre: aw/w valid=%b, expected 11", {axi.awvalid, axi.wvalid});
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({req_ready, axi.awvalid, axi.wvalid, axi.bready, rsp_valid} !== 5'b10000) begin
         n_fail++; $display("FAIL rst_mid_idle: got %b, expected 10000",
                            {req_ready, axi.awvalid, axi.wvalid, axi.bready, rsp_valid});
      end
      @(negedge clk);
      rst = 1'b0;
      last_rdata = 32'h0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid) seen++; end
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL rst_mid_norsp: %0d rsp pulses, expected 0", seen);
      end
      set_cfg(0, 0, 0, 0, 0); cfg_rdata = 32'h0BAD_F00D; cfg_rresp = 2'b00;
      run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, lat, rd, er, got);
      check_txn("rst_mid_after", got, lat, 3, rd, 32'h0BAD_F00D, er, 1'b0);
      last_rdata = 32'h0BAD_F00D;
   endtask

   task automatic test_random();
      int lat; logic [31:0] rd, addr, wd, erd; logic er, eer; bit got, wen;
      logic [3:0] st;
      for (int i = 0; i < 40; i++) begin
         set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 4));
         cfg_rdata = $urandom;
         cfg_rresp = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         cfg_bresp = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         wen = 1'($urandom_range(0, 1));
         addr = $urandom; wd = $urandom; st = 4'($urandom_range(0, 15));
         run_txn(wen, addr, wd, st, lat, rd, er, got);
         erd = wen ? last_rdata : cfg_rdata;
         eer = wen ? (cfg_bresp != 2'b00) : (cfg_rresp != 2'b00);
         check_txn("random", got, lat, exp_lat(wen), rd, erd, er, eer);
         if (!wen) last_rdata = cfg_rdata;
         n_tests++;
         if (wen ? ({rec_awaddr, rec_wdata, rec_wstrb} !== {addr, wd, st})
                 : (rec_araddr !== addr)) begin
            n_fail++; $display("FAIL random_bus: txn %0d wen=%0d addr=%h seen aw=%h ar=%h", i, wen,
                               addr, rec_awaddr, rec_araddr);
         end
      end
      n_tests++;
      if (proto_err) begin
         n_fail++; $display("FAIL random_proto: valid dropped or changed before handshake");
      end
   endtask

`ifdef YSYX_AXIM_TIMEOUT_EN
   task automatic test_timeout();
      int lat; logic [31:0] rd; logic er; bit got;
      set_cfg(1000000, 0, 0, 0, 0);
      run_txn(1'b0, 32'h9000_0000, 32'h0, 4'h0, lat, rd, er, got);
      check_txn("timeout", got, lat, 17, rd, 32'h0, er, 1'b1);
   endtask
`endif

   initial begin
      cfg_ar = 0; cfg_r = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0;
      cfg_rdata = 32'h0; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
      test_reset();
      test_read_basic();
      test_write_split();
      test_read_delayed_err();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef YSYX_AXIM_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
